// File: rtl/syn_but_pipe.sv
// Pipelined radix-2 DIT complex butterfly (A + W*B, A - W*B) feeding a result FIFO.
// Define SYN_BUT_SAT_EN to clamp out-of-range results; otherwise they wrap.
module syn_but_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned TWDL_W     = 16,
    parameter int unsigned BFFR_DEPTH = 8
) (
    input  logic                            clk_ir,
    input  logic                            rst_il,
    input  logic [2*DATA_W-1:0]             sample_a,
    input  logic [2*DATA_W-1:0]             sample_b,
    input  logic [2*TWDL_W-1:0]             twdl,
    input  logic                            sample_rdy,
    input  logic                            res_rd_en,
    output logic [2*DATA_W-1:0]             res,
    output logic                            res_rdy,
    output logic                            bffr_ovrflw,
    output logic                            bffr_underflw,
    output logic [$clog2(BFFR_DEPTH):0]     bffr_occ
);

    localparam int unsigned PROD_W = DATA_W + TWDL_W;
    localparam int unsigned PP_W   = PROD_W + 1;
    localparam int unsigned P_W    = DATA_W + 2;
    localparam int unsigned SUM_W  = DATA_W + 3;
    localparam int unsigned PTR_W  = $clog2(BFFR_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic signed [PP_W-1:0] RND = PP_W'(1) << (TWDL_W - 2);

    // ---------------- Stage 1: input capture ----------------
    logic                r_s1_vld;
    logic [2*DATA_W-1:0] r_s1_a;
    logic [2*DATA_W-1:0] r_s1_b;
    logic [2*TWDL_W-1:0] r_s1_w;

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= sample_rdy;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (sample_rdy) begin
            r_s1_a <= sample_a;
            r_s1_b <= sample_b;
            r_s1_w <= twdl;
        end
    end

    // ---------------- Stage 2: partial products ----------------
    logic signed [DATA_W-1:0] w_b_re;
    logic signed [DATA_W-1:0] w_b_im;
    logic signed [TWDL_W-1:0] w_w_re;
    logic signed [TWDL_W-1:0] w_w_im;
    logic signed [PROD_W-1:0] w_rr;
    logic signed [PROD_W-1:0] w_ii;
    logic signed [PROD_W-1:0] w_ri;
    logic signed [PROD_W-1:0] w_ir;

    assign w_b_re = r_s1_b[2*DATA_W-1:DATA_W];
    assign w_b_im = r_s1_b[DATA_W-1:0];
    assign w_w_re = r_s1_w[2*TWDL_W-1:TWDL_W];
    assign w_w_im = r_s1_w[TWDL_W-1:0];

    assign w_rr = PROD_W'(w_b_re) * PROD_W'(w_w_re);
    assign w_ii = PROD_W'(w_b_im) * PROD_W'(w_w_im);
    assign w_ri = PROD_W'(w_b_re) * PROD_W'(w_w_im);
    assign w_ir = PROD_W'(w_b_im) * PROD_W'(w_w_re);

    logic                     r_s2_vld;
    logic [2*DATA_W-1:0]      r_s2_a;
    logic signed [PROD_W-1:0] r_s2_rr;
    logic signed [PROD_W-1:0] r_s2_ii;
    logic signed [PROD_W-1:0] r_s2_ri;
    logic signed [PROD_W-1:0] r_s2_ir;

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (r_s1_vld) begin
            r_s2_a  <= r_s1_a;
            r_s2_rr <= w_rr;
            r_s2_ii <= w_ii;
            r_s2_ri <= w_ri;
            r_s2_ir <= w_ir;
        end
    end

    // ---------------- Stage 3: combine, round, add/sub ----------------
    logic signed [PP_W-1:0] w_p_re_full;
    logic signed [PP_W-1:0] w_p_im_full;
    logic signed [PP_W-1:0] w_p_re_rnd;
    logic signed [PP_W-1:0] w_p_im_rnd;
    logic signed [PP_W-1:0] w_p_re_sh;
    logic signed [PP_W-1:0] w_p_im_sh;
    logic [P_W-1:0]         w_p_re;
    logic [P_W-1:0]         w_p_im;
    logic [DATA_W-1:0]      w_a_re;
    logic [DATA_W-1:0]      w_a_im;
    logic [SUM_W-1:0]       w_sum_re;
    logic [SUM_W-1:0]       w_sum_im;
    logic [SUM_W-1:0]       w_dif_re;
    logic [SUM_W-1:0]       w_dif_im;

    assign w_p_re_full = {r_s2_rr[PROD_W-1], r_s2_rr} - {r_s2_ii[PROD_W-1], r_s2_ii};
    assign w_p_im_full = {r_s2_ri[PROD_W-1], r_s2_ri} + {r_s2_ir[PROD_W-1], r_s2_ir};
    // Round half up, then drop the Q1.(TWDL_W-1) fraction.
    assign w_p_re_rnd  = w_p_re_full + RND;
    assign w_p_im_rnd  = w_p_im_full + RND;
    assign w_p_re_sh   = w_p_re_rnd >>> (TWDL_W - 1);
    assign w_p_im_sh   = w_p_im_rnd >>> (TWDL_W - 1);
    assign w_p_re      = w_p_re_sh[P_W-1:0];
    assign w_p_im      = w_p_im_sh[P_W-1:0];

    assign w_a_re   = r_s2_a[2*DATA_W-1:DATA_W];
    assign w_a_im   = r_s2_a[DATA_W-1:0];
    assign w_sum_re = {{3{w_a_re[DATA_W-1]}}, w_a_re} + {w_p_re[P_W-1], w_p_re};
    assign w_sum_im = {{3{w_a_im[DATA_W-1]}}, w_a_im} + {w_p_im[P_W-1], w_p_im};
    assign w_dif_re = {{3{w_a_re[DATA_W-1]}}, w_a_re} - {w_p_re[P_W-1], w_p_re};
    assign w_dif_im = {{3{w_a_im[DATA_W-1]}}, w_a_im} - {w_p_im[P_W-1], w_p_im};

    logic [2*DATA_W-1:0] w_sum;
    logic [2*DATA_W-1:0] w_dif;
    logic                w_unused;

`ifdef SYN_BUT_SAT_EN
    function automatic logic [DATA_W-1:0] sat_fn(input logic [SUM_W-1:0] v);
        if ((v[SUM_W-1:DATA_W-1] == '0) || (v[SUM_W-1:DATA_W-1] == '1)) begin
            return v[DATA_W-1:0];
        end else if (v[SUM_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    assign w_sum    = {sat_fn(w_sum_re), sat_fn(w_sum_im)};
    assign w_dif    = {sat_fn(w_dif_re), sat_fn(w_dif_im)};
    assign w_unused = ^{w_p_re_sh[PP_W-1:P_W], w_p_im_sh[PP_W-1:P_W]};
`else
    assign w_sum    = {w_sum_re[DATA_W-1:0], w_sum_im[DATA_W-1:0]};
    assign w_dif    = {w_dif_re[DATA_W-1:0], w_dif_im[DATA_W-1:0]};
    assign w_unused = ^{w_p_re_sh[PP_W-1:P_W], w_p_im_sh[PP_W-1:P_W],
                        w_sum_re[SUM_W-1:DATA_W], w_sum_im[SUM_W-1:DATA_W],
                        w_dif_re[SUM_W-1:DATA_W], w_dif_im[SUM_W-1:DATA_W]};
`endif

    // ---------------- Result FIFO ----------------
    logic [2*DATA_W-1:0] r_mem [BFFR_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [OCC_W-1:0]    r_occ;
    logic [OCC_W-1:0]    w_occ_nxt;
    logic [PTR_W-1:0]    w_wptr_p1;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic [2*DATA_W-1:0] r_res;
    logic                r_res_rdy;
    logic                r_ovf;
    logic                r_udf;

    // Admission and pop both look at occupancy before this cycle's update.
    assign w_wr_ok   = r_s2_vld && (r_occ <= OCC_W'(BFFR_DEPTH - 2));
    assign w_rd_ok   = res_rd_en && (r_occ != '0);
    assign w_wptr_p1 = r_wptr + PTR_W'(1);

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_wr_ok) begin
            w_occ_nxt = w_occ_nxt + OCC_W'(2);
        end
        if (w_rd_ok) begin
            w_occ_nxt = w_occ_nxt - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_ir) begin
        if (w_wr_ok) begin
            r_mem[r_wptr]    <= w_sum;
            r_mem[w_wptr_p1] <= w_dif;
        end
    end

    always_ff @(posedge clk_ir) begin
        if (!rst_il) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_occ     <= '0;
            r_res     <= '0;
            r_res_rdy <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PTR_W'(2);
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_res  <= r_mem[r_rptr];
            end
            r_occ     <= w_occ_nxt;
            r_res_rdy <= w_rd_ok;
            r_ovf     <= r_s2_vld && !w_wr_ok;
            r_udf     <= res_rd_en && (r_occ == '0);
        end
    end

    assign res           = r_res;
    assign res_rdy       = r_res_rdy;
    assign bffr_ovrflw   = r_ovf;
    assign bffr_underflw = r_udf;
    assign bffr_occ      = r_occ;

endmodule
